// File: rtl/y_window_pkg.sv
// y_window_pkg: shared tap count, pixel/hsel types and mod-5 helpers for the vertical filter path
package y_window_pkg;
    localparam int NUM_TAPS = 5;
    localparam int PIX_W    = 8;
    localparam int HSEL_W   = 3;
    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [HSEL_W-1:0] hsel_t;
    // hsel names the physical line buffer (0..4) holding the oldest line; y_window applies its
    // first coefficient to that tap and the centre row is tap (hsel+2) mod 5
    typedef enum logic {FILL, RUN} phase_e;
    function automatic hsel_t mod5_inc(hsel_t x);
        return (x == 3'd4) ? 3'd0 : x + 3'd1;
    endfunction
    function automatic hsel_t mod5_sub(hsel_t a, hsel_t b);
        return (a >= b) ? a - b : a + 3'd5 - b;
    endfunction
endpackage

// File: rtl/y_line_buffer_if.sv
// y_line_buffer_if: raster pixel input and 5-tap column output bundle
interface y_line_buffer_if;
    import y_window_pkg::*;
    pix_t  din;
    logic  validin;
    logic  sof;
    pix_t  dout0, dout1, dout2, dout3, dout4;
    hsel_t hsel;
    logic  validout;
    modport master (output din, validin, sof, input dout0, dout1, dout2, dout3, dout4, hsel, validout);
    modport slave  (input din, validin, sof, output dout0, dout1, dout2, dout3, dout4, hsel, validout);
endinterface

// File: rtl/y_line_buffer_line_ram.sv
// line_ram: single-port read-first line store, read register cleared by reset
module line_ram
    import y_window_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pix_t          wdata,
    output pix_t          rdata
);
    pix_t mem [DEPTH];
    // storage write; contents survive reset
    always_ff @(posedge clock) begin
        if (en && we) mem[addr] <= wdata;
    end
    // read-first: returns the value stored before this cycle's write
    always_ff @(posedge clock) begin
        if (reset) rdata <= '0;
        else if (en) rdata <= mem[addr];
    end
endmodule

// File: rtl/y_line_buffer.sv
// y_line_buffer: raster-to-column stage feeding y_window; optional BORDER_CLAMP_EN replicates the top line
module y_line_buffer
    import y_window_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int COL_W      = 10
) (
    input  logic clock,
    input  logic reset,
    y_line_buffer_if.slave bus
);
    localparam int AI = $clog2(LINE_WIDTH);
    logic [COL_W-1:0] col, eff_col;
    hsel_t wr_line, eff_line, lines_filled, eff_filled, line_q, hsel_q;
    pix_t  byp;
    logic  wrap, validout_q, flag_ok;
    pix_t  rdata [NUM_TAPS];
    pix_t  raw   [NUM_TAPS];
    pix_t  dout  [NUM_TAPS];
    // sof restarts the frame on this very pixel, discarding any partial line
    always_comb begin
        eff_col    = bus.sof ? '0 : col;
        eff_line   = bus.sof ? '0 : wr_line;
        eff_filled = bus.sof ? '0 : lines_filled;
        wrap       = eff_col == COL_W'(LINE_WIDTH - 1);
    end
    // raster position counters, advanced once per valid pixel
    always_ff @(posedge clock) begin
        if (reset) begin
            col          <= '0;
            wr_line      <= '0;
            lines_filled <= '0;
        end else if (bus.validin) begin
            col          <= wrap ? '0 : eff_col + 1'b1;
            wr_line      <= wrap ? mod5_inc(eff_line) : eff_line;
            lines_filled <= (wrap && eff_filled != 3'd4) ? eff_filled + 3'd1 : eff_filled;
        end
    end
    genvar k;
    for (k = 0; k < NUM_TAPS; k++) begin : g_ram
        line_ram #(.DEPTH(LINE_WIDTH), .AW(AI)) u_ram (
            .clock (clock),
            .reset (reset),
            .en    (bus.validin),
            .we    (bus.validin && eff_line == HSEL_W'(k)),
            .addr  (eff_col[AI-1:0]),
            .wdata (bus.din),
            .rdata (rdata[k])
        );
    end
    // sample the incoming pixel and its rotation alongside the RAM reads
    always_ff @(posedge clock) begin
        if (reset) begin
            byp        <= '0;
            line_q     <= '0;
            hsel_q     <= '0;
            validout_q <= 1'b0;
        end else begin
            validout_q <= bus.validin && flag_ok;
            if (bus.validin) begin
                byp    <= bus.din;
                line_q <= eff_line;
                hsel_q <= mod5_inc(eff_line);
            end
        end
    end
    // the line being written reads back stale data, so its tap comes from the bypass register
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) raw[i] = (line_q == HSEL_W'(i)) ? byp : rdata[i];
    end
`ifdef BORDER_CLAMP_EN
    hsel_t filled_q;
    assign flag_ok = 1'b1;
    // remember how many older lines of this frame exist for the sampled pixel
    always_ff @(posedge clock) begin
        if (reset) filled_q <= '0;
        else if (bus.validin) filled_q <= eff_filled;
    end
    // taps older than the frame's first line replicate that first line
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++)
            dout[i] = (mod5_sub(line_q, HSEL_W'(i)) > filled_q) ? raw[mod5_sub(line_q, filled_q)] : raw[i];
    end
`else
    phase_e phase;
    // a column is complete only once four older lines of this frame are stored
    always_comb begin
        phase   = (eff_filled == 3'd4) ? RUN : FILL;
        flag_ok = phase == RUN;
        for (int i = 0; i < NUM_TAPS; i++) dout[i] = raw[i];
    end
`endif
    assign bus.dout0    = dout[0];
    assign bus.dout1    = dout[1];
    assign bus.dout2    = dout[2];
    assign bus.dout3    = dout[3];
    assign bus.dout4    = dout[4];
    assign bus.hsel     = hsel_q;
    assign bus.validout = validout_q;
endmodule

// File: tb/tb_y_line_buffer.sv
// tb_y_line_buffer: randomized and directed checks of y_line_buffer against a frame-image model
module tb_y_line_buffer;
    localparam int LW = 4;
`ifdef BORDER_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;
    y_line_buffer_if bus ();
    y_line_buffer #(.LINE_WIDTH(LW), .COL_W(10)) dut (.clock(clock), .reset(reset), .bus(bus));
    logic [7:0] obs [5];
    assign obs[0] = bus.dout0;
    assign obs[1] = bus.dout1;
    assign obs[2] = bus.dout2;
    assign obs[3] = bus.dout3;
    assign obs[4] = bus.dout4;
    int errors = 0;
    int checks = 0;
    logic [7:0] img [64][LW];
    int m_fl, m_col;
    logic [7:0] exp_d [5];
    bit known [5];
    logic [2:0] exp_h;
    logic exp_v;

    task automatic do_reset();
        bus.validin = 1'b0;
        bus.sof = 1'b0;
        bus.din = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        m_fl = 0;
        m_col = 0;
        exp_v = 1'b0;
        exp_h = '0;
        for (int k = 0; k < 5; k++) begin
            exp_d[k] = '0;
            known[k] = 1'b1;
        end
    endtask

    // drive one cycle and update the model: tap k shows frame line (fl - age), age = (fl - k) mod 5
    task automatic px(input bit v, input bit s, input logic [7:0] d);
        bus.validin = v;
        bus.sof = s;
        bus.din = d;
        @(posedge clock);
        #1;
        exp_v = 1'b0;
        if (v) begin
            if (s) begin
                m_fl = 0;
                m_col = 0;
            end
            img[m_fl % 64][m_col] = d;
            for (int k = 0; k < 5; k++) begin
                int a;
                a = ((m_fl % 5) - k + 5) % 5;
                if (a <= m_fl) begin
                    exp_d[k] = img[(m_fl - a) % 64][m_col];
                    known[k] = 1'b1;
                end else if (CLAMP) begin
                    exp_d[k] = img[0][m_col];
                    known[k] = 1'b1;
                end else known[k] = 1'b0;
            end
            exp_h = 3'((m_fl + 1) % 5);
            exp_v = CLAMP || m_fl >= 4;
            m_col++;
            if (m_col == LW) begin
                m_col = 0;
                m_fl++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.validout !== 1'b0) begin errors++; $display("FAIL reset validout got=%0b exp=0", bus.validout); end
        checks++;
        if (bus.hsel !== 3'd0) begin errors++; $display("FAIL reset hsel got=%0d exp=0", bus.hsel); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs[k] !== 8'h00) begin errors++; $display("FAIL reset dout%0d got=%h exp=00", k, obs[k]); end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4 * LW; i++) begin
            px(1'b1, i == 0, 8'(16 * (i / LW) + i % LW));
            checks++;
            if (bus.validout !== exp_v) begin errors++; $display("FAIL fill validout i=%0d got=%0b exp=%0b", i, bus.validout, exp_v); end
            checks++;
            if (bus.hsel !== exp_h) begin errors++; $display("FAIL fill hsel i=%0d got=%0d exp=%0d", i, bus.hsel, exp_h); end
            for (int k = 0; k < 5; k++) if (known[k]) begin
                checks++;
                if (obs[k] !== exp_d[k]) begin errors++; $display("FAIL fill dout%0d i=%0d got=%h exp=%h", k, i, obs[k], exp_d[k]); end
            end
        end
    endtask

    task automatic test_run();
        logic [7:0] want2 [5];
        logic [7:0] want3 [5];
        want2 = '{8'h02, 8'h12, 8'h22, 8'h32, 8'h42};
        want3 = '{8'h50, 8'h10, 8'h20, 8'h30, 8'h40};
        for (int i = 0; i < 5; i++) begin
            px(1'b1, 1'b0, 8'(16 * m_fl + m_col));
            checks++;
            if (bus.validout !== exp_v) begin errors++; $display("FAIL run validout i=%0d got=%0b exp=%0b", i, bus.validout, exp_v); end
            for (int k = 0; k < 5; k++) if (known[k]) begin
                checks++;
                if (obs[k] !== exp_d[k]) begin errors++; $display("FAIL run dout%0d i=%0d got=%h exp=%h", k, i, obs[k], exp_d[k]); end
            end
            if (i == 2 || i == 4) begin
                checks++;
                if (bus.validout !== 1'b1) begin errors++; $display("FAIL run_const validout i=%0d got=%0b exp=1", i, bus.validout); end
                checks++;
                if (bus.hsel !== ((i == 2) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL run_const hsel i=%0d got=%0d", i, bus.hsel); end
                for (int k = 0; k < 5; k++) begin
                    checks++;
                    if (obs[k] !== ((i == 2) ? want2[k] : want3[k])) begin errors++; $display("FAIL run_const dout%0d i=%0d got=%h", k, i, obs[k]); end
                end
            end
        end
    endtask

    task automatic test_gaps();
        bit vs [7];
        vs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            px(vs[i], 1'b0, 8'(16 * m_fl + m_col));
            checks++;
            if (bus.validout !== exp_v) begin errors++; $display("FAIL gaps validout i=%0d got=%0b exp=%0b", i, bus.validout, exp_v); end
            checks++;
            if (bus.hsel !== exp_h) begin errors++; $display("FAIL gaps hsel i=%0d got=%0d exp=%0d", i, bus.hsel, exp_h); end
            for (int k = 0; k < 5; k++) if (known[k]) begin
                checks++;
                if (obs[k] !== exp_d[k]) begin errors++; $display("FAIL gaps dout%0d i=%0d got=%h exp=%h", k, i, obs[k], exp_d[k]); end
            end
        end
    endtask

    task automatic test_sof();
        int flagged;
        flagged = 0;
        px(1'b1, 1'b0, 8'(16 * m_fl + m_col));
        for (int i = 0; i < 4 * LW + 2; i++) begin
            px(1'b1, i == 0, 8'($urandom));
            if (i < 4 * LW && bus.validout === 1'b1) flagged++;
            checks++;
            if (bus.validout !== exp_v) begin errors++; $display("FAIL sof validout i=%0d got=%0b exp=%0b", i, bus.validout, exp_v); end
            checks++;
            if (bus.hsel !== exp_h) begin errors++; $display("FAIL sof hsel i=%0d got=%0d exp=%0d", i, bus.hsel, exp_h); end
            for (int k = 0; k < 5; k++) if (known[k]) begin
                checks++;
                if (obs[k] !== exp_d[k]) begin errors++; $display("FAIL sof dout%0d i=%0d got=%h exp=%h", k, i, obs[k], exp_d[k]); end
            end
        end
        if (!CLAMP) begin
            checks++;
            if (flagged !== 0) begin errors++; $display("FAIL sof_fill flagged got=%0d exp=0", flagged); end
        end
    endtask

`ifdef BORDER_CLAMP_EN
    task automatic test_clamp();
        logic [7:0] want [5];
        want = '{8'h03, 8'h13, 8'h03, 8'h03, 8'h03};
        do_reset();
        for (int i = 0; i < 2 * LW; i++) begin
            px(1'b1, i == 0, 8'(16 * (i / LW) + i % LW));
            checks++;
            if (bus.validout !== 1'b1) begin errors++; $display("FAIL clamp validout i=%0d got=%0b exp=1", i, bus.validout); end
        end
        checks++;
        if (bus.hsel !== 3'd2) begin errors++; $display("FAIL clamp hsel got=%0d exp=2", bus.hsel); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs[k] !== want[k]) begin errors++; $display("FAIL clamp dout%0d got=%h exp=%h", k, obs[k], want[k]); end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            px($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, 8'($urandom));
            checks++;
            if (bus.validout !== exp_v) begin errors++; $display("FAIL rand validout i=%0d got=%0b exp=%0b", i, bus.validout, exp_v); end
            checks++;
            if (bus.hsel !== exp_h) begin errors++; $display("FAIL rand hsel i=%0d got=%0d exp=%0d", i, bus.hsel, exp_h); end
            for (int k = 0; k < 5; k++) if (known[k]) begin
                checks++;
                if (obs[k] !== exp_d[k]) begin errors++; $display("FAIL rand dout%0d i=%0d got=%h exp=%h", k, i, obs[k], exp_d[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_run();
        test_gaps();
        test_sof();
`ifdef BORDER_CLAMP_EN
        test_clamp();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
